// File: rtl/bnn_packer.sv
// Packs single activation bits from the bnn unit into 32-bit words of matrix_size bits,
// with a one-word output register behind a valid/ready handshake.
module bnn_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        ms_WE,
    input  logic [31:0] ExtImmE,
    input  logic        bit_valid,
    input  logic        bit_in,
    output logic        bit_ready,
    input  logic        pack_flush,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [31:0] word_out,
    output logic [5:0]  word_len,
    output logic        busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 6;
    localparam logic [CNT_W-1:0] MS_RESET = CNT_W'(9);
    localparam logic [CNT_W-1:0] MS_MAX   = CNT_W'(DATA_W);

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

    out_state_e        state_q, state_d;
    logic [CNT_W-1:0]  ms_q, ms_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  len_q, len_d;

    logic              at_last;
    logic              stall;
    logic              accept;
    logic              completion;
    logic [CNT_W-1:0]  cnt_after;
    logic [DATA_W-1:0] acc_with;
    logic [CNT_W-1:0]  ms_wdata;

    logic unused_imm;
    assign unused_imm = ^ExtImmE[DATA_W-1:CNT_W];

    assign ms_wdata   = ExtImmE[CNT_W-1:0];
    assign word_valid = (state_q == OUT_FULL);
    assign busy       = (acc_cnt_q != '0) || word_valid;
    assign word_out   = word_q;
    assign word_len   = len_q;
    assign bit_ready  = !stall;

    // A completing accept is only blocked when the held word cannot drain this cycle.
    assign at_last = (acc_cnt_q == ms_q - CNT_W'(1));
    assign stall   = word_valid && !word_ready && at_last;
    assign accept  = bit_valid && !stall;

    always_comb begin
        state_d   = state_q;
        ms_d      = ms_q;
        acc_cnt_d = acc_cnt_q;
        acc_d     = acc_q;
        word_d    = word_q;
        len_d     = len_q;

        cnt_after = acc_cnt_q + CNT_W'(accept);
        acc_with  = acc_q;
        if (accept && bit_in) begin
            acc_with[acc_cnt_q[4:0]] = 1'b1;
        end
        // A flush folds in any bit accepted this cycle; the full-word case has cnt_after == ms_q.
        completion = (accept && at_last) || (pack_flush && !stall && (cnt_after != '0));

        if (ms_WE && !busy && (ms_wdata != '0) && (ms_wdata <= MS_MAX)) begin
            ms_d = ms_wdata;
        end

        if (completion) begin
            word_d    = acc_with;
            len_d     = cnt_after;
            acc_d     = '0;
            acc_cnt_d = '0;
            state_d   = OUT_FULL;
        end else begin
            acc_d     = acc_with;
            acc_cnt_d = cnt_after;
            if (state_q == OUT_FULL && word_ready) begin
                state_d = OUT_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= OUT_EMPTY;
            ms_q      <= MS_RESET;
            acc_cnt_q <= '0;
            acc_q     <= '0;
            word_q    <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            ms_q      <= ms_d;
            acc_cnt_q <= acc_cnt_d;
            acc_q     <= acc_d;
            word_q    <= word_d;
            len_q     <= len_d;
        end
    end

endmodule

// File: tb/tb_bnn_packer.sv
// Directed bench for bnn_packer: a per-cycle vector table followed by hand-written
// sequences for the 32-bit and 1-bit word sizes.
module tb_bnn_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_WE;
    logic [31:0] ExtImmE;
    logic        bit_valid;
    logic        bit_in;
    logic        bit_ready;
    logic        pack_flush;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_out;
    logic [5:0]  word_len;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    bnn_packer dut (
        .clk        (clk),
        .reset      (reset),
        .ms_WE      (ms_WE),
        .ExtImmE    (ExtImmE),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .bit_ready  (bit_ready),
        .pack_flush (pack_flush),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_len   (word_len),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Inputs are applied for one clock; expectations are the outputs seen before that clock's edge.
    typedef struct {
        bit          chk;
        bit          chkw;
        bit          rst;
        bit          we;
        logic [31:0] imm;
        bit          bv;
        bit          bi;
        bit          fl;
        bit          wr;
        bit          br;
        bit          wv;
        logic [31:0] wo;
        logic [5:0]  wl;
        bit          bs;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit chk, input bit chkw, input bit rst, input bit we,
                       input logic [31:0] imm, input bit bv, input bit bi, input bit fl,
                       input bit wr, input bit br, input bit wv, input logic [31:0] wo,
                       input logic [5:0] wl, input bit bs);
        vec_t v;
        v.chk = chk; v.chkw = chkw; v.rst = rst; v.we = we; v.imm = imm;
        v.bv = bv; v.bi = bi; v.fl = fl; v.wr = wr;
        v.br = br; v.wv = wv; v.wo = wo; v.wl = wl; v.bs = bs;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    initial begin
        logic [31:0] pat;
        int          waited;
        bit          b;

        reset = 1'b1; ms_WE = 1'b0; ExtImmE = '0; bit_valid = 1'b0;
        bit_in = 1'b0; pack_flush = 1'b0; word_ready = 1'b0;

        //   chk chkw rst we imm  bv bi fl wr   br wv wo      wl  bs
        add(0, 0, 1, 0, 0,   0, 0, 0, 1,   1, 0, 0,      0,  0);
        add(1, 1, 0, 0, 0,   0, 0, 0, 1,   1, 0, 0,      0,  0);
        // default size 9: 1,1,0,1,1,0,0,1,1
        add(1, 0, 0, 0, 0,   1, 1, 0, 1,   1, 0, 0,      0,  0);
        add(1, 0, 0, 0, 0,   1, 1, 0, 1,   1, 0, 0,      0,  1);
        add(1, 0, 0, 0, 0,   1, 0, 0, 1,   1, 0, 0,      0,  1);
        add(1, 0, 0, 0, 0,   1, 1, 0, 1,   1, 0, 0,      0,  1);
        add(1, 0, 0, 0, 0,   1, 1, 0, 1,   1, 0, 0,      0,  1);
        add(1, 0, 0, 0, 0,   1, 0, 0, 1,   1, 0, 0,      0,  1);
        add(1, 0, 0, 0, 0,   1, 0, 0, 1,   1, 0, 0,      0,  1);
        add(1, 0, 0, 0, 0,   1, 1, 0, 1,   1, 0, 0,      0,  1);
        add(1, 0, 0, 0, 0,   1, 1, 0, 1,   1, 0, 0,      0,  1);
        add(1, 1, 0, 0, 0,   0, 0, 0, 0,   1, 1, 32'h19B, 9, 1);
        add(1, 1, 0, 0, 0,   0, 0, 0, 1,   1, 1, 32'h19B, 9, 1);
        add(1, 0, 0, 0, 0,   0, 0, 0, 1,   1, 0, 0,      0,  0);
        // size writes: 4 legal, 0 and 33 ignored, 9 while busy ignored
        add(1, 0, 0, 1, 4,   0, 0, 0, 1,   1, 0, 0,      0,  0);
        add(1, 0, 0, 1, 0,   0, 0, 0, 1,   1, 0, 0,      0,  0);
        add(1, 0, 0, 1, 33,  0, 0, 0, 1,   1, 0, 0,      0,  0);
        add(1, 0, 0, 0, 0,   1, 1, 0, 1,   1, 0, 0,      0,  0);
        add(1, 0, 0, 1, 9,   1, 0, 0, 1,   1, 0, 0,      0,  1);
        add(1, 0, 0, 0, 0,   1, 1, 0, 1,   1, 0, 0,      0,  1);
        add(1, 0, 0, 0, 0,   1, 1, 0, 1,   1, 0, 0,      0,  1);
        // word 0xD held; next word 1,1,0 accumulates, 4th bit stalls, stalled flush ignored
        add(1, 1, 0, 0, 0,   0, 0, 0, 0,   1, 1, 32'hD,  4,  1);
        add(1, 1, 0, 0, 0,   1, 1, 0, 0,   1, 1, 32'hD,  4,  1);
        add(1, 1, 0, 0, 0,   1, 1, 0, 0,   1, 1, 32'hD,  4,  1);
        add(1, 1, 0, 0, 0,   1, 0, 0, 0,   1, 1, 32'hD,  4,  1);
        add(1, 1, 0, 0, 0,   1, 1, 0, 0,   0, 1, 32'hD,  4,  1);
        add(1, 1, 0, 0, 0,   0, 0, 1, 0,   0, 1, 32'hD,  4,  1);
        add(1, 1, 0, 0, 0,   1, 1, 0, 1,   1, 1, 32'hD,  4,  1);
        add(1, 1, 0, 0, 0,   0, 0, 0, 0,   1, 1, 32'hB,  4,  1);
        add(1, 1, 0, 0, 0,   0, 0, 0, 1,   1, 1, 32'hB,  4,  1);
        add(1, 0, 0, 0, 0,   0, 0, 0, 1,   1, 0, 0,      0,  0);
        // size 9, 1,0,1 then flush; empty flush yields nothing
        add(1, 0, 0, 1, 9,   0, 0, 0, 1,   1, 0, 0,      0,  0);
        add(1, 0, 0, 0, 0,   1, 1, 0, 1,   1, 0, 0,      0,  0);
        add(1, 0, 0, 0, 0,   1, 0, 0, 1,   1, 0, 0,      0,  1);
        add(1, 0, 0, 0, 0,   1, 1, 0, 1,   1, 0, 0,      0,  1);
        add(1, 0, 0, 0, 0,   0, 0, 1, 1,   1, 0, 0,      0,  1);
        add(1, 1, 0, 0, 0,   0, 0, 0, 0,   1, 1, 32'h5,  3,  1);
        add(1, 1, 0, 0, 0,   0, 0, 0, 1,   1, 1, 32'h5,  3,  1);
        add(1, 0, 0, 0, 0,   0, 0, 1, 1,   1, 0, 0,      0,  0);
        add(1, 0, 0, 0, 0,   0, 0, 0, 1,   1, 0, 0,      0,  0);
        // flush together with the 3rd bit
        add(1, 0, 0, 0, 0,   1, 1, 0, 1,   1, 0, 0,      0,  0);
        add(1, 0, 0, 0, 0,   1, 1, 0, 1,   1, 0, 0,      0,  1);
        add(1, 0, 0, 0, 0,   1, 1, 1, 1,   1, 0, 0,      0,  1);
        add(1, 1, 0, 0, 0,   0, 0, 0, 0,   1, 1, 32'h7,  3,  1);
        add(1, 1, 0, 0, 0,   0, 0, 0, 1,   1, 1, 32'h7,  3,  1);
        // 1-bit word pending, 5 bits accumulated, then reset mid-word
        add(1, 0, 0, 0, 0,   1, 1, 1, 0,   1, 0, 0,      0,  0);
        add(1, 1, 0, 0, 0,   1, 1, 0, 0,   1, 1, 32'h1,  1,  1);
        add(1, 1, 0, 0, 0,   1, 0, 0, 0,   1, 1, 32'h1,  1,  1);
        add(1, 1, 0, 0, 0,   1, 1, 0, 0,   1, 1, 32'h1,  1,  1);
        add(1, 1, 0, 0, 0,   1, 0, 0, 0,   1, 1, 32'h1,  1,  1);
        add(1, 1, 0, 0, 0,   1, 1, 0, 0,   1, 1, 32'h1,  1,  1);
        add(1, 1, 1, 0, 0,   1, 1, 0, 0,   1, 1, 32'h1,  1,  1);
        add(1, 1, 0, 0, 0,   0, 0, 0, 1,   1, 0, 0,      0,  0);
        // fresh 9-bit word 0x101 confirms size returned to 9
        add(1, 0, 0, 0, 0,   1, 1, 0, 1,   1, 0, 0,      0,  0);
        for (int k = 0; k < 7; k++) add(1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0,   1, 1, 0, 1,   1, 0, 0,      0,  1);
        add(1, 1, 0, 0, 0,   0, 0, 0, 1,   1, 1, 32'h101, 9, 1);
        add(1, 0, 0, 0, 0,   0, 0, 0, 1,   1, 0, 0,      0,  0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; ms_WE = vecs[i].we; ExtImmE = vecs[i].imm;
            bit_valid = vecs[i].bv; bit_in = vecs[i].bi; pack_flush = vecs[i].fl;
            word_ready = vecs[i].wr;
            #1;
            if (vecs[i].chk) begin
                tests++;
                if (bit_ready !== vecs[i].br || word_valid !== vecs[i].wv || busy !== vecs[i].bs ||
                    (vecs[i].chkw && (word_out !== vecs[i].wo || word_len !== vecs[i].wl))) begin
                    failed++;
                    $display("FAIL vec%0d: got br=%b wv=%b wo=%h wl=%0d busy=%b, expected br=%b wv=%b wo=%h wl=%0d busy=%b",
                             i, bit_ready, word_valid, word_out, word_len, busy,
                             vecs[i].br, vecs[i].wv, vecs[i].wo, vecs[i].wl, vecs[i].bs);
                end
            end
        end

        // Full 32-bit word
        @(negedge clk);
        reset = 1'b0; ms_WE = 1'b1; ExtImmE = 32'd32; bit_valid = 1'b0; pack_flush = 1'b0; word_ready = 1'b1;
        @(negedge clk);
        ms_WE = 1'b0;
        pat = 32'hA5A5_3C0F;
        for (int k = 0; k < 32; k++) begin
            bit_valid = 1'b1; bit_in = pat[k];
            #1;
            if (!bit_ready) check("w32_ready", 32'(bit_ready), 32'd1);
            @(negedge clk);
        end
        bit_valid = 1'b0;
        waited = 0;
        while (!word_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        #1;
        check("w32_timeout", 32'(waited), 32'd0);
        check("w32_word", word_out, pat);
        check("w32_len", 32'(word_len), 32'd32);

        // Size 1: every accept completes; stall while the held word is not taken
        @(negedge clk);
        ms_WE = 1'b1; ExtImmE = 32'd1;
        @(negedge clk);
        ms_WE = 1'b0; word_ready = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
        @(negedge clk);
        bit_in = 1'b0; pack_flush = 1'b1;
        #1;
        check("w1_valid", 32'(word_valid), 32'd1);
        check("w1_stall", 32'(bit_ready), 32'd0);
        @(negedge clk);
        pack_flush = 1'b0;
        #1;
        b = word_valid;
        check("w1_hold_valid", 32'(b), 32'd1);
        check("w1_hold_word", word_out, 32'd1);
        check("w1_hold_len", 32'(word_len), 32'd1);
        word_ready = 1'b1;
        #1;
        check("w1_ready_back", 32'(bit_ready), 32'd1);
        @(negedge clk);
        bit_valid = 1'b0;
        #1;
        check("w1_next_valid", 32'(word_valid), 32'd1);
        check("w1_next_word", word_out, 32'd0);
        check("w1_next_len", 32'(word_len), 32'd1);
        @(negedge clk);
        #1;
        check("w1_drained", 32'(word_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/bnn_packer.md
BNN_PACKER -- requirements
Module: bnn_packer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port ms_WE, input, 1 bit: write enable for the matrix_size register.
REQ-004 SHALL have port ExtImmE, input, 32 bits: matrix_size write data; only bits [5:0] are used.
REQ-005 SHALL have port bit_valid, input, 1 bit: an activation bit is offered on bit_in.
REQ-006 SHALL have port bit_in, input, 1 bit: binary activation value produced by the bnn unit.
REQ-007 SHALL have port bit_ready, output, 1 bit: the packer accepts bit_in this cycle.
REQ-008 SHALL have port pack_flush, input, 1 bit: emit the current partial word, zero-padded.
REQ-009 SHALL have port word_valid, output, 1 bit: word_out and word_len hold a packed word.
REQ-010 SHALL have port word_ready, input, 1 bit: the consumer takes the word this cycle.
REQ-011 SHALL have port word_out, output, 32 bits: packed activation vector, first bit at bit 0.
REQ-012 SHALL have port word_len, output, 6 bits: number of valid bits in word_out (1..32).
REQ-013 SHALL have port busy, output, 1 bit: high when acc_cnt != 0 or word_valid = 1.

Function
REQ-014 SHALL hold matrix_size in a 6-bit register; legal values are 1..32.
REQ-015 SHALL load ExtImmE[5:0] into matrix_size when ms_WE = 1 and busy = 0.
- The write SHALL be ignored when busy = 1.
- The write SHALL be ignored when ExtImmE[5:0] = 0 or > 32.
REQ-016 SHALL accept a bit when bit_valid = 1 and bit_ready = 1.
- The accepted bit goes to accumulator bit acc_cnt; acc_cnt then increments.
- Accumulator bits at positions >= acc_cnt SHALL be held at 0.
REQ-017 SHALL treat an accept with acc_cnt = matrix_size-1 as a completion.
- The accumulator, including the new bit, moves to the output register.
- word_len = matrix_size.
- acc_cnt returns to 0 and the accumulator clears.
- word_valid = 1 from the next cycle.
REQ-018 SHALL treat pack_flush = 1 as a completion of the partial word, with word_len equal to the bit count.
- If a bit is accepted in the same cycle, that bit SHALL be included first.
- pack_flush SHALL have no effect when the resulting bit count is 0.
REQ-019 SHALL clear word_valid on a cycle where word_valid = 1 and word_ready = 1, unless a completion occurs in the same cycle.
- If a completion occurs in that cycle, the new word SHALL load and word_valid SHALL stay 1.
REQ-020 SHALL hold word_out and word_len stable while word_valid = 1 and word_ready = 0.
REQ-021 SHALL drive bit_ready = 0 only when all of the following hold:
- word_valid = 1;
- word_ready = 0;
- acc_cnt = matrix_size-1.
- bit_ready SHALL be 1 in every other case. Accumulation continues while the output is held.
REQ-022 SHALL stall pack_flush under the same condition as REQ-021 when acc_cnt != 0.
- While stalled, the flush SHALL be ignored. The upstream holds pack_flush until it can complete.
REQ-023 SHALL implement the output side as a two-state FSM.
- OUT_EMPTY -> OUT_FULL on a completion.
- OUT_FULL -> OUT_EMPTY on word_ready = 1 with no completion.
- OUT_FULL stays OUT_FULL on word_ready = 1 with a completion, or on word_ready = 0.
REQ-024 SHALL add no combinational path from bit_in to word_out. Latency is 1 cycle from the completing accept to word_valid = 1.

Reset
REQ-025 SHALL, on reset = 1 at a clock edge, set the following regardless of other inputs, including mid-word:
- matrix_size = 9;
- acc_cnt = 0, accumulator = 0;
- word_valid = 0, word_out = 0, word_len = 0;
- FSM = OUT_EMPTY.
REQ-026 SHALL drive bit_ready = 1 and busy = 0 in the first cycle after reset.

Verification
REQ-027 Default size, word_ready = 1; feed bits 1,1,0,1,1,0,0,1,1 (0x19B, LSB first) -> one cycle after the 9th accept: word_valid = 1, word_out = 0x0000019B, word_len = 9.
REQ-028 ms_WE = 1, ExtImmE = 4 while idle -> 4 bits 1,0,1,1 yield word_out = 0x0000000D, word_len = 4. ms_WE with ExtImmE = 0, 33, or while busy -> size unchanged.
REQ-029 Size 4, word_ready = 0 -> the first word is held; 3 more bits are accepted; the 4th is offered with bit_ready = 0. Raise word_ready -> the 4th is accepted, the second word loads in the same cycle, word_valid stays 1.
REQ-030 Size 9; 3 bits 1,0,1 then pack_flush -> word_out = 0x00000005, word_len = 3. pack_flush with 0 bits -> no word.
REQ-031 pack_flush with bit_valid = 1 as 3rd bit (1,1,1) -> word_out = 0x00000007, word_len = 3.
REQ-032 Reset asserted after 5 of 9 bits with a word pending -> next cycle: word_valid = 0, busy = 0, matrix_size = 9. A fresh 9-bit word packs correctly.
